// File: rtl/f16_fmac_dot_seq.sv
// +----------------------------------------------------------------------------+
// | f16_fmac_dot_seq : FP16 dot-product sequencer around a combinational FMAC   |
// |                    datapath (normal operands only, truncating, no GRS).    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module f16_fmac_normal_no_grs (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic [15:0] z,
    output logic [15:0] result
);
    logic               prod_sign;
    logic [21:0]        prod;
    logic signed [8:0]  prod_exp;
    logic signed [8:0]  z_exp;
    logic [10:0]        z_mant;
    logic [23:0]        a_al;
    logic [23:0]        b_al;
    logic signed [8:0]  exp_max;
    logic signed [8:0]  diff;
    logic [23:0]        sum;
    logic               sum_sign;
    logic [4:0]         lead;
    logic signed [8:0]  res_exp;
    logic [23:0]        norm;
    logic [9:0]         frac;

    // Operands with a zero exponent field count as zero; a zero term gets a
    // very small exponent so it can never become the alignment reference.
    always_comb begin
        prod_sign = x[15] ^ y[15];
        prod      = 22'({1'b1, x[9:0]}) * 22'({1'b1, y[9:0]});
        prod_exp  = $signed({4'b0, x[14:10]}) + $signed({4'b0, y[14:10]}) - 9'sd15;
        if (x[14:10] == 5'd0 || y[14:10] == 5'd0) begin
            prod     = 22'd0;
            prod_exp = -9'sd200;
        end
        z_mant = {1'b1, z[9:0]};
        z_exp  = $signed({4'b0, z[14:10]});
        if (z[14:10] == 5'd0) begin
            z_mant = 11'd0;
            z_exp  = -9'sd200;
        end

        // Both terms carry their binary point at bit 20.
        a_al = {2'b00, prod};
        b_al = {3'b000, z_mant, 10'b0};
        if (prod_exp >= z_exp) begin
            exp_max = prod_exp;
            diff    = prod_exp - z_exp;
            b_al    = (diff > 9'sd23) ? 24'd0 : (b_al >> diff[4:0]);
        end else begin
            exp_max = z_exp;
            diff    = z_exp - prod_exp;
            a_al    = (diff > 9'sd23) ? 24'd0 : (a_al >> diff[4:0]);
        end

        if (prod_sign == z[15]) begin
            sum      = a_al + b_al;
            sum_sign = prod_sign;
        end else if (a_al >= b_al) begin
            sum      = a_al - b_al;
            sum_sign = prod_sign;
        end else begin
            sum      = b_al - a_al;
            sum_sign = z[15];
        end

        lead = 5'd0;
        for (int i = 0; i < 24; i++) begin
            if (sum[i]) lead = 5'(i);
        end
        res_exp = exp_max - 9'sd20 + $signed({4'b0, lead});
        norm    = sum << (5'd23 - lead);
        frac    = 10'(norm >> 13);

        if (sum == 24'd0 || res_exp <= 9'sd0)
            result = 16'h0000;
        else if (res_exp >= 9'sd31)
            result = {sum_sign, 15'h7FFF};
        else
            result = {sum_sign, res_exp[4:0], frac};
    end
endmodule

module f16_fmac_dot_seq #(
    parameter int MAX_LEN = 16,
    parameter int CNT_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [15:0]      init_z,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_x,
    input  logic [15:0]      in_y,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_result,
    output logic [CNT_W-1:0] out_count,
    output logic             out_trunc
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [15:0]      acc;
    logic [CNT_W-1:0] count;
    logic [15:0]      fmac_out;

    f16_fmac_normal_no_grs u_fmac (
        .x      (in_x),
        .y      (in_y),
        .z      (acc),
        .result (fmac_out)
    );

    assign out_result = acc;
    assign out_count  = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= 16'h0000;
            count     <= '0;
            out_trunc <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc       <= init_z;
                        count     <= '0;
                        out_trunc <= 1'b0;
                        state     <= RUN;
                        busy      <= 1'b1;
                        in_ready  <= 1'b1;
                    end
                end
                RUN: begin
                    if (in_valid && in_ready) begin
                        acc   <= fmac_out;
                        count <= count + CNT_W'(1);
                        // in_last takes priority, so a job ending exactly at MAX_LEN is not truncated.
                        if (in_last || count == CNT_W'(MAX_LEN - 1)) begin
                            state     <= DONE;
                            out_trunc <= ~in_last;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

`default_nettype wire
